// File: rtl/serial_sub4.sv
// serial_sub4: bit-serial subtractor, Diff = A - B - Bin, LSB first, one bit per clock.
// Start is accepted in IDLE or DONE. Bits are processed on the following WIDTH edges.
// Done pulses for one cycle once the result is committed.
// Diff, Bout and (optional) Ovf change only on the edge that enters DONE.
//
// Optional feature: define SUB_OVF_EN to add the Ovf port (signed overflow of the result).
//
// Ports:
//   Clk    in   rising-edge clock
//   Rst    in   asynchronous, active-high reset
//   Start  in   request; accepted only in IDLE or DONE
//   A      in   [WIDTH] minuend, sampled on the accepting edge
//   B      in   [WIDTH] subtrahend, sampled on the accepting edge
//   Bin    in   borrow in, sampled on the accepting edge
//   Busy   out  high while bits are being processed
//   Done   out  one-cycle pulse; Diff/Bout valid from this cycle
//   Diff   out  [WIDTH] result, held until the next result is committed
//   Bout   out  borrow out of the MSB, held with Diff
//   Ovf    out  two's-complement overflow, held with Diff (SUB_OVF_EN only)

module serial_sub4 #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout
`ifdef SUB_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] res_next;
    logic             last_bit;

    // One full-subtractor cell applied to the current LSBs
    assign d_bit    = a_sr[0] ^ b_sr[0] ^ br;
    assign br_next  = (~a_sr[0] & b_sr[0]) | (~a_sr[0] & br) | (b_sr[0] & br);
    // Result bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB
    assign res_next = {d_bit, res_sr[WIDTH-1:1]};
    assign last_bit = (cnt == CW'(WIDTH - 1));

    // Control FSM and datapath registers
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            Busy   <= 1'b0;
            Done   <= 1'b0;
            Diff   <= '0;
            Bout   <= 1'b0;
`ifdef SUB_OVF_EN
            Ovf    <= 1'b0;
`endif
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        a_sr   <= A;
                        b_sr   <= B;
                        br     <= Bin;
                        res_sr <= '0;
                        cnt    <= '0;
                        Busy   <= 1'b1;
                        state  <= SHIFT;
                    end else begin
                        state  <= IDLE;
                    end
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    br     <= br_next;
                    res_sr <= res_next;
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        // Commit the whole result at once; outputs never show partial bits
                        Diff  <= res_next;
                        Bout  <= br_next;
`ifdef SUB_OVF_EN
                        // Borrow into MSB differs from borrow out of MSB -> signed overflow
                        Ovf   <= br ^ br_next;
`endif
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub4.sv
// tb_serial_sub4: self-checking bench for serial_sub4 at WIDTH=4 and WIDTH=8.
// Expected results come from plain integer arithmetic on the operands.

module tb_serial_sub4;

    logic       Clk;
    logic       Rst;

    logic       start4, bin4, busy4, done4, bout4;
    logic [3:0] a4, b4, diff4;
    logic       start8, bin8, busy8, done8, bout8;
    logic [7:0] a8, b8, diff8;
`ifdef SUB_OVF_EN
    logic       ovf4, ovf8;
    logic       held_ovf4, held_ovf8;
`endif

    logic [3:0] held_diff4;
    logic       held_bout4;
    logic [7:0] held_diff8;
    logic       held_bout8;

    int checks = 0;
    int errors = 0;

    serial_sub4 #(.WIDTH(4)) dut4 (
        .Clk   (Clk),
        .Rst   (Rst),
        .Start (start4),
        .A     (a4),
        .B     (b4),
        .Bin   (bin4),
        .Busy  (busy4),
        .Done  (done4),
        .Diff  (diff4),
        .Bout  (bout4)
`ifdef SUB_OVF_EN
        ,
        .Ovf   (ovf4)
`endif
    );

    serial_sub4 #(.WIDTH(8)) dut8 (
        .Clk   (Clk),
        .Rst   (Rst),
        .Start (start8),
        .A     (a8),
        .B     (b8),
        .Bin   (bin8),
        .Busy  (busy8),
        .Done  (done8),
        .Diff  (diff8),
        .Bout  (bout8)
`ifdef SUB_OVF_EN
        ,
        .Ovf   (ovf8)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: modulo difference and unsigned borrow from integer arithmetic
    function automatic void model(input int w, input int unsigned a, input int unsigned b,
                                  input int unsigned bin, output int unsigned d, output int unsigned bo);
        longint full;
        longint m;
        m    = longint'(1) << w;
        full = longint'(a) - longint'(b) - longint'(bin);
        d    = 32'(((full % m) + m) % m);
        bo   = (full < 0) ? 1 : 0;
    endfunction

`ifdef SUB_OVF_EN
    // Reference: signed result out of the representable range
    function automatic int unsigned ovf_model(input int w, input int unsigned a, input int unsigned b,
                                              input int unsigned bin);
        longint m, sa, sb, sr;
        m  = longint'(1) << w;
        sa = (longint'(a) >= m / 2) ? longint'(a) - m : longint'(a);
        sb = (longint'(b) >= m / 2) ? longint'(b) - m : longint'(b);
        sr = sa - sb - longint'(bin);
        return (sr < -(m / 2) || sr > (m / 2) - 1) ? 1 : 0;
    endfunction
`endif

    // Called at a negedge with dut4 in IDLE or DONE; returns at the negedge in DONE
    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bin, input bit hold);
        int unsigned ed, eb;
        model(4, 32'(a), 32'(b), 32'(bin), ed, eb);
        start4 = 1'b1;
        a4 = a;
        b4 = b;
        bin4 = bin;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            // Operands and Start wiggle during SHIFT and must be ignored
            start4 = hold;
            a4 = 4'($urandom);
            b4 = 4'($urandom);
            bin4 = 1'($urandom);
            check("busy4_shift", 32'(busy4), 32'(1));
            check("done4_shift", 32'(done4), 32'(0));
            check("diff4_held", 32'(diff4), 32'(held_diff4));
            check("bout4_held", 32'(bout4), 32'(held_bout4));
`ifdef SUB_OVF_EN
            check("ovf4_held", 32'(ovf4), 32'(held_ovf4));
`endif
        end
        @(negedge Clk);
        check("done4", 32'(done4), 32'(1));
        check("busy4_done", 32'(busy4), 32'(0));
        check("diff4", 32'(diff4), ed);
        check("bout4", 32'(bout4), eb);
        held_diff4 = 4'(ed);
        held_bout4 = 1'(eb);
`ifdef SUB_OVF_EN
        check("ovf4", 32'(ovf4), ovf_model(4, 32'(a), 32'(b), 32'(bin)));
        held_ovf4 = 1'(ovf_model(4, 32'(a), 32'(b), 32'(bin)));
`endif
    endtask

    task automatic idle4();
        start4 = 1'b0;
        @(negedge Clk);
        check("done4_idle", 32'(done4), 32'(0));
        check("busy4_idle", 32'(busy4), 32'(0));
        check("diff4_idle", 32'(diff4), 32'(held_diff4));
        check("bout4_idle", 32'(bout4), 32'(held_bout4));
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin);
        int unsigned ed, eb;
        model(8, 32'(a), 32'(b), 32'(bin), ed, eb);
        start8 = 1'b1;
        a8 = a;
        b8 = b;
        bin8 = bin;
        for (int k = 0; k < 8; k++) begin
            @(negedge Clk);
            start8 = 1'b0;
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            bin8 = 1'($urandom);
            check("busy8_shift", 32'(busy8), 32'(1));
            check("done8_shift", 32'(done8), 32'(0));
            check("diff8_held", 32'(diff8), 32'(held_diff8));
        end
        @(negedge Clk);
        check("done8", 32'(done8), 32'(1));
        check("diff8", 32'(diff8), ed);
        check("bout8", 32'(bout8), eb);
        held_diff8 = 8'(ed);
        held_bout8 = 1'(eb);
`ifdef SUB_OVF_EN
        check("ovf8", 32'(ovf8), ovf_model(8, 32'(a), 32'(b), 32'(bin)));
        held_ovf8 = 1'(ovf_model(8, 32'(a), 32'(b), 32'(bin)));
`endif
        start8 = 1'b0;
        @(negedge Clk);
        check("done8_idle", 32'(done8), 32'(0));
        check("bout8_idle", 32'(bout8), 32'(held_bout8));
    endtask

    initial begin
        Rst = 1'b1;
        start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        held_diff4 = '0; held_bout4 = 1'b0;
        held_diff8 = '0; held_bout8 = 1'b0;
`ifdef SUB_OVF_EN
        held_ovf4 = 1'b0; held_ovf8 = 1'b0;
`endif
        repeat (2) @(negedge Clk);
        check("rst_busy4", 32'(busy4), 32'(0));
        check("rst_done4", 32'(done4), 32'(0));
        check("rst_diff4", 32'(diff4), 32'(0));
        check("rst_bout4", 32'(bout4), 32'(0));
        check("rst_diff8", 32'(diff8), 32'(0));
`ifdef SUB_OVF_EN
        check("rst_ovf4", 32'(ovf4), 32'(0));
`endif
        Rst = 1'b0;
        @(negedge Clk);

        // Directed cases
        op4(4'd9, 4'd3, 1'b0, 1'b0); idle4();
        op4(4'd3, 4'd9, 1'b0, 1'b0); idle4();
        op4(4'd0, 4'd0, 1'b1, 1'b0); idle4();
        // Start held through SHIFT, then back-to-back from DONE
        op4(4'd6, 4'd1, 1'b0, 1'b1);
        op4(4'd5, 4'd2, 1'b0, 1'b0); idle4();

        // Asynchronous reset while bit 2 is being processed
        start4 = 1'b1; a4 = 4'hC; b4 = 4'h3; bin4 = 1'b0;
        @(negedge Clk);
        start4 = 1'b0;
        @(posedge Clk);
        @(posedge Clk);
        #2 Rst = 1'b1;
        #1;
        check("arst_busy4", 32'(busy4), 32'(0));
        check("arst_done4", 32'(done4), 32'(0));
        check("arst_diff4", 32'(diff4), 32'(0));
        check("arst_bout4", 32'(bout4), 32'(0));
`ifdef SUB_OVF_EN
        check("arst_ovf4", 32'(ovf4), 32'(0));
        held_ovf4 = 1'b0;
        held_ovf8 = 1'b0;
`endif
        @(negedge Clk);
        #2 Rst = 1'b0;
        held_diff4 = '0; held_bout4 = 1'b0;
        held_diff8 = '0; held_bout8 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge Clk);
            check("arst_no_done4", 32'(done4), 32'(0));
            check("arst_idle_busy4", 32'(busy4), 32'(0));
        end
        op4(4'hF, 4'h1, 1'b0, 1'b0); idle4();

        // Signed overflow boundaries
        op4(4'd8, 4'd1, 1'b0, 1'b0); idle4();
        op4(4'd7, 4'hF, 1'b0, 1'b0);
        op4(4'd5, 4'd3, 1'b0, 1'b0); idle4();

        // Randomized operands, random hold of Start and random back-to-back
        for (int n = 0; n < 60; n++) begin
            op4(4'($urandom), 4'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle4();
        end
        idle4();

        // Wider instance
        op8(8'h00, 8'h01, 1'b0);
        op8(8'h80, 8'h01, 1'b0);
        for (int n = 0; n < 12; n++) begin
            op8(8'($urandom), 8'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
